// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch front end. It owns the PC and issues one sequential
// fetch per cycle to a synchronous instruction memory that has a fixed
// one-cycle latency. Each returned instruction is buffered with its PC in a
// small FIFO. Decode drains the FIFO through a valid/ready handshake. A
// redirect reloads the PC and discards everything that is buffered or in
// flight.
//
// Ports:
//   Clk          clock, rising edge
//   Clr          asynchronous active-high reset
//   imem_req     fetch request strobe (combinational)
//   imem_addr    fetch address, equal to the PC register, word aligned
//   imem_rdata   instruction data, valid the cycle after a request
//   redir_valid  redirect strobe (taken branch or jump)
//   redir_pc     redirect target; the low 2 bits are ignored
//   inst_valid   FIFO head holds a valid instruction (combinational)
//   inst         instruction at the FIFO head
//   inst_pc      PC of the instruction at the FIFO head
//   inst_ready   decode accepts the head entry this cycle
module fetch_queue_unit #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned DEPTH    = 4
) (
    input  logic              Clk,
    input  logic              Clr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];

    logic [PTR_W-1:0]  count;
    logic [OCC_W-1:0]  occ;
    logic              pop;
    logic              wr_en;

    // Occupancy after this cycle: buffered + in flight - consumed.
    // A request is issued only while a slot is guaranteed for its response.
    always_comb begin
        count      = wr_ptr - rd_ptr;
        inst_valid = (count != '0) && !redir_valid && !Clr;
        pop        = inst_valid && inst_ready;
        occ        = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        imem_req   = !Clr && !redir_valid && (occ < OCC_W'(DEPTH));
        wr_en      = inflight && !redir_valid;
        imem_addr  = pc;
        inst       = mem_data[rd_ptr[AW-1:0]];
        inst_pc    = mem_pc[rd_ptr[AW-1:0]];
    end

    // PC, in-flight tracking and FIFO pointers. A redirect overrides
    // issue, response write and pop.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redir_valid) begin
            pc       <= redir_pc & ~ADDR_W'(3);
            rd_ptr   <= wr_ptr;
            inflight <= 1'b0;
        end else begin
            if (imem_req) begin
                inflight    <= 1'b1;
                inflight_pc <= pc;
                pc          <= pc + ADDR_W'(4);
            end else begin
                inflight <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage. No reset is needed because the pointers qualify every entry.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_data[wr_ptr[AW-1:0]] <= imem_rdata;
            mem_pc[wr_ptr[AW-1:0]]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit. It uses DEPTH=4 and RESET_PC=0x100.
// The memory model returns f(addr) one cycle after each request.
module tb_fetch_queue_unit;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks   = 0;
    int failures = 0;

    fetch_queue_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h100),
        .DEPTH   (4)
    ) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Instruction memory: the data for a request appears in the next cycle.
    initial imem_rdata = '0;
    always @(posedge Clk) begin
        if (imem_req) imem_rdata <= f(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle: inputs may change just after the falling edge.
    task automatic adv(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    // Pulse reset, check the reset outputs, then leave the bench in cycle C0.
    task automatic do_reset(input logic rdy);
        @(negedge Clk);
        Clr = 1'b1; redir_valid = 1'b0; redir_pc = '0; inst_ready = rdy;
        #1;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req",   32'(imem_req),   32'd0);
        chk("rst_addr",  imem_addr,       32'h100);
        @(negedge Clk);
        Clr = 1'b0;
        #1;
        chk("c0_req",  32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr,     32'h100);
    endtask

    initial begin
        Clr = 1'b1; redir_valid = 1'b0; redir_pc = '0; inst_ready = 1'b1;

        // Streaming out of reset
        do_reset(1'b1);
        adv(1);
        chk("s_c1_addr",  imem_addr,        32'h104);
        chk("s_c1_valid", 32'(inst_valid),  32'd0);
        for (int k = 0; k < 5; k++) begin
            adv(1);
            chk("s_valid", 32'(inst_valid), 32'd1);
            chk("s_pc",    inst_pc,         32'h100 + 32'(4 * k));
            chk("s_inst",  inst,            f(32'h100 + 32'(4 * k)));
            chk("s_addr",  imem_addr,       32'h108 + 32'(4 * k));
        end

        // Backpressure: the queue fills with 0x100..0x10C and the PC holds at 0x110
        do_reset(1'b0);
        adv(3);
        chk("bp_c3_req",  32'(imem_req), 32'd1);
        chk("bp_c3_addr", imem_addr,     32'h10C);
        adv(1);
        chk("bp_c4_req",  32'(imem_req), 32'd0);
        chk("bp_c4_addr", imem_addr,     32'h110);
        adv(5);
        chk("bp_c9_req",   32'(imem_req),   32'd0);
        chk("bp_c9_addr",  imem_addr,       32'h110);
        chk("bp_c9_valid", 32'(inst_valid), 32'd1);
        chk("bp_c9_pc",    inst_pc,         32'h100);
        adv(1);
        inst_ready = 1'b1;
        #1;
        chk("bp_rel_req",  32'(imem_req), 32'd1);
        chk("bp_rel_addr", imem_addr,     32'h110);
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_pc",    inst_pc,         32'h100 + 32'(4 * k));
            chk("bp_inst",  inst,            f(32'h100 + 32'(4 * k)));
            adv(1);
        end

        // Redirect while three entries are buffered and one request is in flight
        do_reset(1'b0);
        adv(4);
        redir_valid = 1'b1; redir_pc = 32'h2003;
        #1;
        chk("rd_valid", 32'(inst_valid), 32'd0);
        chk("rd_req",   32'(imem_req),   32'd0);
        adv(1);
        redir_valid = 1'b0; inst_ready = 1'b1;
        #1;
        chk("rd1_addr",  imem_addr,       32'h2000);
        chk("rd1_req",   32'(imem_req),   32'd1);
        chk("rd1_valid", 32'(inst_valid), 32'd0);
        adv(1);
        chk("rd2_valid", 32'(inst_valid), 32'd0);
        chk("rd2_addr",  imem_addr,       32'h2004);
        adv(1);
        chk("rd3_valid", 32'(inst_valid), 32'd1);
        chk("rd3_pc",    inst_pc,         32'h2000);
        chk("rd3_inst",  inst,            f(32'h2000));
        adv(1);
        chk("rd4_pc",    inst_pc,         32'h2004);

        // Redirects in two consecutive cycles: the last one wins
        adv(1);
        redir_valid = 1'b1; redir_pc = 32'h400;
        #1;
        chk("bb1_valid", 32'(inst_valid), 32'd0);
        adv(1);
        redir_pc = 32'h800;
        #1;
        chk("bb2_valid", 32'(inst_valid), 32'd0);
        chk("bb2_req",   32'(imem_req),   32'd0);
        adv(1);
        redir_valid = 1'b0;
        #1;
        chk("bb3_addr",  imem_addr,       32'h800);
        chk("bb3_valid", 32'(inst_valid), 32'd0);
        adv(1);
        chk("bb4_valid", 32'(inst_valid), 32'd0);
        adv(1);
        chk("bb5_valid", 32'(inst_valid), 32'd1);
        chk("bb5_pc",    inst_pc,         32'h800);

        // PC wrap-around past the top of the address space
        adv(1);
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
        #1;
        adv(1);
        redir_valid = 1'b0;
        #1;
        chk("w1_addr", imem_addr, 32'hFFFF_FFFC);
        adv(1);
        chk("w2_addr", imem_addr, 32'h0);
        adv(1);
        chk("w3_valid", 32'(inst_valid), 32'd1);
        chk("w3_pc",    inst_pc,         32'hFFFF_FFFC);
        chk("w3_inst",  inst,            f(32'hFFFF_FFFC));
        adv(1);
        chk("w4_pc",    inst_pc,         32'h0);
        chk("w4_inst",  inst,            f(32'h0));

        // Reset asserted mid-stream
        adv(2);
        chk("mr_pre_valid", 32'(inst_valid), 32'd1);
        Clr = 1'b1;
        #1;
        chk("mr_valid", 32'(inst_valid), 32'd0);
        chk("mr_req",   32'(imem_req),   32'd0);
        chk("mr_addr",  imem_addr,       32'h100);
        adv(1);
        Clr = 1'b0;
        #1;
        chk("mr1_req",   32'(imem_req),   32'd1);
        chk("mr1_addr",  imem_addr,       32'h100);
        chk("mr1_valid", 32'(inst_valid), 32'd0);
        adv(1);
        chk("mr2_valid", 32'(inst_valid), 32'd0);
        adv(1);
        chk("mr3_valid", 32'(inst_valid), 32'd1);
        chk("mr3_pc",    inst_pc,         32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
